// File: rtl/neural_host_sequencer.sv
// Host-side master for the neural accelerator's external neuron-RAM bus: loads an input
// vector under accelerator reset, runs it, then streams the result words back out.
module neural_host_sequencer #(
  parameter int unsigned INPUT_BASE     = 20,
  parameter int unsigned RESET_HOLD     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_count,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic       acc_reset,
  output logic [7:0] acc_write_adr,
  output logic [7:0] acc_write_data,
  output logic       acc_wr_en,
  output logic [7:0] acc_read_adr,
  input  logic [7:0] acc_read_data,
  input  logic       acc_finished,
  input  logic [7:0] acc_result_base,
  input  logic [7:0] acc_result_count
);

  localparam logic [7:0]  InBase   = 8'(INPUT_BASE);
  localparam logic [7:0]  HoldLast = 8'(RESET_HOLD - 1);
  localparam logic [15:0] RunLast  = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StRun    = 3'd3;
  localparam logic [2:0] StRdAddr = 3'd4;
  localparam logic [2:0] StRdCap  = 3'd5;
  localparam logic [2:0] StOut    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] run_q, run_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  rcount_q, rcount_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_adr_q, wr_adr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        timeout_q, timeout_d;
  logic        done_q, done_d;
  logic        readout;
  logic        last_word;

  assign readout   = (state_q == StRdAddr) || (state_q == StRdCap) || (state_q == StOut);
  assign last_word = (k_q == rcount_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    run_d     = run_q;
    base_d    = base_q;
    rcount_d  = rcount_q;
    k_d       = k_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    wr_en_d   = 1'b0;
    wr_adr_d  = 8'd0;
    wr_data_d = 8'd0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d   = in_count;
          timeout_d = 1'b0;
          idx_d     = 8'd0;
          hold_d    = 8'd0;
          state_d   = (in_count == 8'd0) ? StSettle : StLoad;
        end
      end
      StLoad: begin
        // Write is registered, so it lands in the cycle after the handshake.
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_adr_d  = InBase + idx_q;
          wr_data_d = in_data;
          idx_d     = idx_q + 8'd1;
          if (idx_q == count_q - 8'd1) begin
            hold_d  = 8'd0;
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (hold_q == HoldLast) begin
          hold_d  = 8'd0;
          run_d   = 16'd0;
          state_d = StRun;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StRun: begin
        // Finished takes priority over a coincident timeout.
        if (acc_finished) begin
          base_d   = acc_result_base;
          rcount_d = acc_result_count;
          k_d      = 8'd0;
          if (acc_result_count == 8'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRdAddr;
          end
        end else if (run_q == RunLast) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          run_d = run_q + 16'd1;
        end
      end
      StRdAddr: state_d = StRdCap;
      StRdCap: begin
        rdata_d = acc_read_data;
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          if (last_word) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = StRdAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= 8'd0;
      idx_q     <= 8'd0;
      hold_q    <= 8'd0;
      run_q     <= 16'd0;
      base_q    <= 8'd0;
      rcount_q  <= 8'd0;
      k_q       <= 8'd0;
      rdata_q   <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= 8'd0;
      wr_data_q <= 8'd0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      run_q     <= run_d;
      base_q    <= base_d;
      rcount_q  <= rcount_d;
      k_q       <= k_d;
      rdata_q   <= rdata_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign in_ready       = (state_q == StLoad);
  assign out_valid      = (state_q == StOut);
  assign out_data       = out_valid ? rdata_q : 8'd0;
  assign out_last       = out_valid && last_word;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign timeout_err    = timeout_q;
  // Accelerator stays in reset (external bus selected) until the run phase.
  assign acc_reset      = (state_q == StIdle) || (state_q == StLoad) || (state_q == StSettle);
  assign acc_wr_en      = wr_en_q;
  assign acc_write_adr  = wr_adr_q;
  assign acc_write_data = wr_data_q;
  assign acc_read_adr   = readout ? (base_q + k_q) : 8'd0;

endmodule

// File: tb/tb_neural_host_sequencer.sv
// Directed bench for neural_host_sequencer with a small accelerator model
// (registered result RAM, finished flag raised a set number of RUN cycles in).
module tb_neural_host_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] in_count;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic       acc_reset;
  logic [7:0] acc_write_adr;
  logic [7:0] acc_write_data;
  logic       acc_wr_en;
  logic [7:0] acc_read_adr;
  logic [7:0] acc_read_data;
  logic       acc_finished;
  logic [7:0] acc_result_base;
  logic [7:0] acc_result_count;

  neural_host_sequencer #(
    .INPUT_BASE    (20),
    .RESET_HOLD    (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .in_count        (in_count),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err),
    .acc_reset       (acc_reset),
    .acc_write_adr   (acc_write_adr),
    .acc_write_data  (acc_write_data),
    .acc_wr_en       (acc_wr_en),
    .acc_read_adr    (acc_read_adr),
    .acc_read_data   (acc_read_data),
    .acc_finished    (acc_finished),
    .acc_result_base (acc_result_base),
    .acc_result_count(acc_result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accelerator model
  logic [7:0] res_mem [256];
  int fin_delay;
  int run_cyc;
  int wr_cnt;
  int ov_cnt;

  always @(posedge clk) begin
    acc_read_data <= res_mem[acc_read_adr];
    run_cyc       <= acc_reset ? 0 : run_cyc + 1;
    if (acc_wr_en) wr_cnt <= wr_cnt + 1;
    if (out_valid) ov_cnt <= ov_cnt + 1;
  end

  assign acc_finished = !acc_reset && (fin_delay >= 0) && (run_cyc >= fin_delay);

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_out(input string tag, input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!out_valid && cyc < limit);
    check(tag, out_valid, 1);
  endtask

  task automatic wait_done(input string tag, input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < limit);
    check(tag, done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int w0;
    int ov0;
    logic [7:0] vec [3];
    logic       pat [5];

    n_checks = 0;
    n_errors = 0;
    vec = '{8'h11, 8'h22, 8'h33};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    reset = 1'b1;
    start = 1'b0;
    in_count = 8'd0;
    in_valid = 1'b0;
    in_data = 8'd0;
    out_ready = 1'b1;
    fin_delay = -1;
    acc_result_base = 8'd0;
    acc_result_count = 8'd0;

    // Reset state
    repeat (3) tick();
    check("rst_acc_reset", acc_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_wr_en", acc_wr_en, 0);
    check("rst_read_adr", acc_read_adr, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    tick();

    // Job 1: three continuous inputs, two result words
    res_mem[0] = 8'h5A;
    res_mem[1] = 8'hA5;
    fin_delay = 40;
    acc_result_base = 8'd0;
    acc_result_count = 8'd2;
    w0 = wr_cnt;
    start = 1'b1;
    in_count = 8'd3;
    tick();
    start = 1'b0;
    check("j1_in_ready", in_ready, 1);
    check("j1_busy", busy, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vec[i];
      tick();
      check("j1_wr_en", acc_wr_en, 1);
      check("j1_wr_adr", acc_write_adr, 32'(20 + i));
      check("j1_wr_data", acc_write_data, vec[i]);
    end
    in_valid = 1'b0;
    check("j1_ready_after_last", in_ready, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("j1_settle_reset", acc_reset, 1);
    end
    check("j1_wr_idle", acc_wr_en, 0);
    tick();
    check("j1_run_reset", acc_reset, 0);
    check("j1_wr_count", wr_cnt - w0, 3);
    wait_out("j1_w0_valid", 200, cyc);
    check("j1_w0_latency", cyc, 43);
    check("j1_w0_data", out_data, 8'h5A);
    check("j1_w0_last", out_last, 0);
    check("j1_w0_adr", acc_read_adr, 0);
    wait_out("j1_w1_valid", 10, cyc);
    check("j1_w1_spacing", cyc, 3);
    check("j1_w1_data", out_data, 8'hA5);
    check("j1_w1_last", out_last, 1);
    check("j1_w1_adr", acc_read_adr, 1);
    tick();
    check("j1_done", done, 1);
    check("j1_idle_busy", busy, 0);
    check("j1_idle_reset", acc_reset, 1);
    check("j1_idle_valid", out_valid, 0);
    tick();
    check("j1_done_pulse", done, 0);

    // Job 2: zero inputs, wrapped readout, output stall
    res_mem[255] = 8'hC3;
    fin_delay = 5;
    acc_result_base = 8'hFF;
    acc_result_count = 8'd2;
    out_ready = 1'b0;
    w0 = wr_cnt;
    start = 1'b1;
    in_count = 8'd0;
    tick();
    start = 1'b0;
    check("j2_skip_load", in_ready, 0);
    check("j2_busy", busy, 1);
    wait_out("j2_w0_valid", 50, cyc);
    for (int i = 0; i < 6; i++) begin
      check("j2_stall_valid", out_valid, 1);
      check("j2_stall_data", out_data, 8'hC3);
      check("j2_stall_adr", acc_read_adr, 8'hFF);
      tick();
    end
    check("j2_stall_last", out_last, 0);
    out_ready = 1'b1;
    wait_out("j2_w1_valid", 10, cyc);
    check("j2_w1_data", out_data, 8'h5A);
    check("j2_w1_wrap_adr", acc_read_adr, 0);
    check("j2_w1_last", out_last, 1);
    tick();
    check("j2_done", done, 1);
    check("j2_no_writes", wr_cnt - w0, 0);

    // Job 3: gapped input, ignored start, then timeout
    fin_delay = -1;
    w0 = wr_cnt;
    ov0 = ov_cnt;
    start = 1'b1;
    in_count = 8'd3;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i];
      in_data = 8'h40 + 8'(i);
      start = (i == 2);
      in_count = (i == 2) ? 8'd1 : 8'd3;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("j3_last_wr_en", acc_wr_en, 1);
    check("j3_last_wr_adr", acc_write_adr, 22);
    check("j3_last_wr_data", acc_write_data, 8'h44);
    check("j3_ready_low", in_ready, 0);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (acc_reset && cyc < 20);
    check("j3_run_reached", acc_reset, 0);
    wait_done("j3_timeout_done", 300, cyc);
    check("j3_timeout_cycles", cyc, 100);
    check("j3_timeout_err", timeout_err, 1);
    check("j3_timeout_reset", acc_reset, 1);
    check("j3_timeout_busy", busy, 0);
    check("j3_no_output", ov_cnt - ov0, 0);
    check("j3_wr_count", wr_cnt - w0, 3);
    tick();
    check("j3_done_pulse", done, 0);
    check("j3_err_sticky", timeout_err, 1);

    // Job 4: start clears timeout_err; zero result count finishes directly
    fin_delay = 3;
    acc_result_count = 8'd0;
    start = 1'b1;
    in_count = 8'd0;
    tick();
    start = 1'b0;
    check("j4_err_cleared", timeout_err, 0);
    wait_done("j4_done", 50, cyc);
    check("j4_done_cycles", cyc, 8);
    check("j4_no_output", ov_cnt - ov0, 0);

    // Job 5: reset after two of four words
    w0 = wr_cnt;
    start = 1'b1;
    in_count = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h61;
    tick();
    in_data = 8'h62;
    tick();
    in_data = 8'h63;
    reset = 1'b1;
    tick();
    check("j5_rst_busy", busy, 0);
    check("j5_rst_in_ready", in_ready, 0);
    check("j5_rst_wr_en", acc_wr_en, 0);
    check("j5_rst_wr_adr", acc_write_adr, 0);
    check("j5_rst_acc_reset", acc_reset, 1);
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    check("j5_wr_count", wr_cnt - w0, 2);
    check("j5_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/neural_host_sequencer.md
Name: neural_host_sequencer

Overview:
- Host-side master for the neural accelerator's external neuron-RAM bus.
- Streams an input vector into neuron RAM while holding the accelerator in reset, then releases it and waits for its finished flag.
- Reads back result_word_count words starting at result_base_address and presents them on a valid/ready output stream.
- Sits between the system-level data path and the accelerator top.

Parameters:
- INPUT_BASE, 20, neuron-RAM address of input word 0 (the layer-0 read bank).
- RESET_HOLD, 4, cycles acc_reset stays high after the last input write before release; range 2..255.
- TIMEOUT_CYCLES, 65535, maximum RUN cycles before aborting; 16-bit.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- in_count  in  8  number of input words, latched on start.
- in_valid  in  1  input word valid.
- in_data  in  8  input word.
- in_ready  out  1  input handshake ready.
- out_valid  out  1  result word valid.
- out_data  out  8  result word.
- out_last  out  1  marks the final result word.
- out_ready  in  1  downstream ready.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse at job end.
- timeout_err  out  1  sticky; cleared on reset or accepted start.
- acc_reset  out  1  drives accelerator reset, which also selects the external bus.
- acc_write_adr  out  8  neuron-RAM write address.
- acc_write_data  out  8  neuron-RAM write data.
- acc_wr_en  out  1  neuron-RAM write enable.
- acc_read_adr  out  8  neuron-RAM read address.
- acc_read_data  in  8  neuron-RAM read data, valid one clock after the address is sampled.
- acc_finished  in  1  accelerator finished.
- acc_result_base  in  8  accelerator result_base_address.
- acc_result_count  in  8  accelerator result_word_count.

Behaviour:
- Reset values: state IDLE; acc_reset=1; every other output 0; counters 0.
- States: IDLE, LOAD, SETTLE, RUN, RD_ADDR, RD_CAP, OUT.
- IDLE:
  - acc_reset=1.
  - start=1 latches in_count, clears timeout_err, idx=0.
  - Next state is LOAD, or SETTLE if in_count==0.
- LOAD:
  - in_ready=1, combinational from state.
  - Each in_valid&in_ready handshake registers acc_wr_en=1, acc_write_adr=INPUT_BASE+idx (mod 256), acc_write_data=in_data. The write appears the cycle after the handshake.
  - acc_wr_en is 0 in every cycle without a preceding handshake. One word per cycle max.
  - The handshake with idx==count-1 moves to SETTLE, so in_ready is 0 the next cycle.
- SETTLE:
  - acc_reset=1; hold counter runs RESET_HOLD cycles, which covers the final registered write.
  - Then RUN; acc_reset=0 from the first RUN cycle.
- RUN:
  - acc_reset=0; cycle counter increments each cycle.
  - acc_finished=1: latch acc_result_base and acc_result_count that same cycle, k=0.
    - Latched count==0: done pulse, go to IDLE.
    - Otherwise go to RD_ADDR.
  - Counter reaching TIMEOUT_CYCLES without acc_finished: timeout_err=1, done pulse, IDLE.
  - acc_finished wins if it coincides with timeout.
- Readout (acc_reset stays 0; the accelerator's finished keeps the external bus selected):
  - RD_ADDR: acc_read_adr=base+k (mod 256), driven combinationally and held through RD_CAP.
  - RD_CAP: capture acc_read_data into out_data.
  - OUT: out_valid=1, out_last=(k==count-1).
    - out_data, out_valid and out_last stay stable until out_ready.
    - On handshake: k++, next RD_ADDR; or, if it was the last word, done pulse and IDLE.
  - Throughput: 1 word per 3 cycles when out_ready is held high.
- acc_read_adr is 0 outside the readout states; acc_write_* is 0 except during a write cycle.
- busy=(state!=IDLE). start is ignored while busy.
- Reset mid-operation: everything returns to reset values on the next edge.
  - No partial write is issued after reset.
  - acc_reset is high in the cycle after reset.
- Address wrap: INPUT_BASE+idx and base+k wrap modulo 256 with no error.

Test Plan:
- in_count=3, data 0x11,0x22,0x33 continuous -> writes to 20,21,22 on consecutive cycles; acc_reset=1 until RESET_HOLD cycles after the last write, then 0.
- Model raises acc_finished 40 cycles into RUN with base=0, count=2, RAM[0]=0x5A, RAM[1]=0xA5 -> out stream 0x5A, 0xA5; out_last only on 0xA5; one done pulse; acc_reset=1 the cycle after.
- out_ready held low 6 cycles on word 0 -> out_valid/out_data stable, acc_read_adr not advanced; after release the stream completes unchanged.
- in_valid with gaps (1,0,0,1,1) for count 3 -> exactly 3 writes; start pulsed mid-LOAD ignored; in_count=0 -> LOAD skipped, 0 writes.
- TIMEOUT_CYCLES=100, acc_finished never asserted -> timeout_err=1 and done after 100 RUN cycles; acc_reset=1; no out_valid; next start clears timeout_err.
- reset asserted after 2 of 4 loaded words -> next cycle IDLE, acc_wr_en=0, in_ready=0, busy=0, acc_reset=1.
